// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request, instruction queue to decode
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misaligned,
`endif
  output logic        halted
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(FIFO_DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic [63:0]   pending_pc_q, pending_pc_d;
  logic          pending_q, pending_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [63:0]   pc_mem    [FIFO_DEPTH];

  logic          deq, capture, halt_word, enq, issue;
  logic [CW:0]   occ;
  logic [63:0]   redirect_tgt;
  logic          redirect_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic          misaligned_q, misaligned_d;
  assign redirect_tgt     = redirect_pc;
  assign redirect_bad     = |redirect_pc[1:0];
  assign fetch_misaligned = misaligned_q;
`else
  assign redirect_tgt     = redirect_pc & ~64'h3;
  assign redirect_bad     = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign halted    = halted_q;
  assign out_valid = (count_q != '0) && !redirect_valid;
  assign out_instr = (count_q != '0) ? instr_mem[rd_ptr_q] : 32'h0;
  assign out_pc    = (count_q != '0) ? pc_mem[rd_ptr_q]    : 64'h0;

  always_comb begin
    deq       = out_valid && out_ready;
    capture   = pending_q && !redirect_valid;
    halt_word = capture && (imem_instr == 32'h0);
    enq       = capture && !halt_word;
    occ       = {1'b0, count_q} + {{CW{1'b0}}, pending_q} + {{CW{1'b0}}, deq};
    // Capturing the halt word also blocks the issue in that same cycle so the PC stops right after it.
    issue     = !redirect_valid && !halted_q && !halt_word && (occ < DEPTH_OCC);
  end

  always_comb begin
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    pending_d    = 1'b0;
    halted_d     = halted_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif
    if (redirect_valid) begin
      pc_d     = redirect_tgt;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      halted_d = redirect_bad;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_d = redirect_bad;
`endif
    end else begin
      if (issue) begin
        pending_d    = 1'b1;
        pending_pc_d = pc_q;
        pc_d         = pc_q + 64'd4;
      end
      if (halt_word) halted_d = 1'b1;
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      pending_pc_q <= 64'h0;
      pending_q    <= 1'b0;
      halted_q     <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      pending_q    <= pending_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  // Queue storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= imem_instr;
      pc_mem[wr_ptr_q]    <= pending_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (optionally with FETCH_MISALIGN_TRAP_EN)
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr = 32'h0;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misaligned (fetch_misaligned),
`endif
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    case (a)
      64'h00:  return 32'h00500113;
      64'h04:  return 32'h00a00193;
      64'h08:  return 32'h003100b3;
      64'h38:  return 32'h00208663;
      64'h3C:  return 32'h00000000;
      default: return {a[23:0], 8'h13};
    endcase
  endfunction

  always @(posedge clk) imem_instr <= imem_word(imem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = start + 64'(4 * i);
      e.instr = imem_word(e.pc);
      sb_q.push_back(e);
    end
  endtask

  // Every accepted head is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("deliv_pc", out_pc, e.pc);
        check("deliv_instr", 64'(out_instr), 64'(e.instr));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Wait for the scoreboard to empty, then stop accepting before the next sample point.
  task automatic drain_and_stall(input int max_cycles);
    for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) @(posedge clk);
    #1 out_ready = 1'b0;
    check("sb_drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic pulse_redirect(input logic [63:0] tgt);
    sb_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    @(negedge clk);
    check("redir_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
  endtask

  initial begin
    int found;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b1;

    // reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_imem_addr", imem_addr, 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_halted", 64'(halted), 64'd0);

    // sequential fetch and first-word latency
    do_reset();
    push_seq(64'h0, 3);
    @(negedge clk);
    check("lat_pre_edge1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_edge1", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("seq_out_valid", 64'(out_valid), 64'd1);
    end
    drain_and_stall(10);

    // backpressure fills the queue, then full-with-dequeue streaming
    out_ready = 1'b0;
    do_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_imem_addr", imem_addr, 64'h10);
    check("bp_head_pc", out_pc, 64'h0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    push_seq(64'h0, 13);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // redirect while the head is 0x10
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_pc == 64'h10) found = 1;
    end
    check("redir_found_head", 64'(found), 64'd1);
    begin
      exp_t e;
      e.pc = 64'h38;
      e.instr = 32'h00208663;
      sb_q.delete();
      sb_q.push_back(e);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h38;
    @(negedge clk);
    check("redir_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 redirect_valid = 1'b0;

    // halt on the zero word at 0x3C
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("halt_sb_empty", 64'(sb_q.size()), 64'd0);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_imem_addr", imem_addr, 64'h40);
    check("halt_out_valid", 64'(out_valid), 64'd0);

    // redirect out of halt, then reset mid-stream
    @(posedge clk);
    #1;
    pulse_redirect(64'h0);
    push_seq(64'h0, 8);
    check("restart_halted", 64'(halted), 64'd0);
    for (int i = 0; i < 40 && sb_q.size() > 5; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_delivered", 64'(sb_q.size()), 64'd5);
    reset = 1'b1;
    out_ready = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_imem_addr", imem_addr, 64'h0);

    // misaligned redirect
    @(posedge clk);
    @(posedge clk);
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    pulse_redirect(64'h6);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mis_flag", 64'(fetch_misaligned), 64'd1);
    check("mis_halted", 64'(halted), 64'd1);
    check("mis_imem_addr", imem_addr, 64'h6);
    check("mis_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    pulse_redirect(64'h8);
    check("mis_clear_flag", 64'(fetch_misaligned), 64'd0);
    check("mis_clear_halted", 64'(halted), 64'd0);
    push_seq(64'h8, 2);
    drain_and_stall(20);
`else
    pulse_redirect(64'h6);
    @(negedge clk);
    check("align_imem_addr", imem_addr, 64'h4);
    push_seq(64'h4, 3);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain_and_stall(20);
    check("align_halted", 64'(halted), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
